// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: two-digit 7-segment time-multiplexing controller.
// Splits a 4-bit binary value into tens/units, alternates the shared BCD
// digit between the units and tens enables, and debounces a push-button
// that toggles a display-hold (freeze) mode.
// Optional build macro: DISP_BLANKING_EN inserts a blank slot between digits.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLANK_CYC    = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       btn_in,
  output logic [3:0] digit_bcd,
  output logic       pin_uni,
  output logic       pin_dec,
  output logic       hold_led
);

  // Slot counter is shared by digit and blank slots, so size it for the longer.
  localparam int SLOT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W    = (SLOT_MAX > 2) ? $clog2(SLOT_MAX) : 1;
  localparam int DB_W     = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYC - 1);
`ifdef DISP_BLANKING_EN
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNI    = 3'd1,
    S_DEC    = 3'd2
`ifdef DISP_BLANKING_EN
    ,
    S_BLK_UD = 3'd3,
    S_BLK_DU = 3'd4
`endif
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       disp_reg;
  logic             hold_reg;
  logic             sync1_reg;
  logic             sync2_reg;
  logic             db_level_reg;
  logic [DB_W-1:0]  db_cnt_reg;

  logic             capture;
  logic             press;
  logic             tens;
  logic [3:0]       units;

  // A new frame is sampled only when entering the units slot and not frozen;
  // hold_reg is the pre-toggle value if a press lands on the same edge.
  assign capture = (state_next == S_UNI) && (state_reg != S_UNI) && !hold_reg;

  // Debounced level is about to rise: the only event that flips hold.
  assign press = sync2_reg && !db_level_reg && (db_cnt_reg == DB_LAST);

  // Value is at most 15, so the tens digit is a single bit.
  assign tens  = (disp_reg >= 4'd10);
  assign units = tens ? (disp_reg - 4'd10) : disp_reg;

  assign hold_led = hold_reg;

  // State register and slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and slot-counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    case (state_reg)
      S_IDLE: begin
        state_next = S_UNI;
        cnt_next   = '0;
      end
      S_UNI: begin
        if (cnt_reg == REFRESH_LAST) begin
`ifdef DISP_BLANKING_EN
          state_next = S_BLK_UD;
`else
          state_next = S_DEC;
`endif
          cnt_next   = '0;
        end
      end
      S_DEC: begin
        if (cnt_reg == REFRESH_LAST) begin
`ifdef DISP_BLANKING_EN
          state_next = S_BLK_DU;
`else
          state_next = S_UNI;
`endif
          cnt_next   = '0;
        end
      end
`ifdef DISP_BLANKING_EN
      S_BLK_UD: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = S_DEC;
          cnt_next   = '0;
        end
      end
      S_BLK_DU: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = S_UNI;
          cnt_next   = '0;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from registered state; blank slots keep showing the digit
  // of the slot just left, which disp_reg still holds unchanged.
  always_comb begin
    digit_bcd = 4'd0;
    pin_uni   = 1'b0;
    pin_dec   = 1'b0;
    case (state_reg)
      S_UNI: begin
        digit_bcd = units;
        pin_uni   = 1'b1;
      end
      S_DEC: begin
        digit_bcd = {3'b000, tens};
        pin_dec   = tens;
      end
`ifdef DISP_BLANKING_EN
      S_BLK_UD: digit_bcd = units;
      S_BLK_DU: digit_bcd = {3'b000, tens};
`endif
      default: digit_bcd = 4'd0;
    endcase
  end

  // Frame capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg <= 4'd0;
    end else if (capture) begin
      disp_reg <= value;
    end
  end

  // Button synchronizer and debouncer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      db_level_reg <= 1'b0;
      db_cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
      if (sync2_reg == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        db_level_reg <= sync2_reg;
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  // Hold toggles on each accepted press; releases are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= 1'b0;
    end else if (press) begin
      hold_reg <= ~hold_reg;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: table-driven scan vectors plus
// hand-written sequences for debounce/hold and asynchronous reset.
// Honours DISP_BLANKING_EN to select the matching expected scan pattern.
module tb_display_scan_ctrl;

  localparam int REFRESH_DIV  = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int BLANK_CYC    = 2;

`ifdef DISP_BLANKING_EN
  localparam int         TO_DEC      = REFRESH_DIV + BLANK_CYC;
  localparam logic [3:0] START_VALUE = 4'd12;
  localparam int         HELD_UNITS  = 2;
  localparam int         HELD_TENS   = 1;
  localparam int         HELD_DEC    = 1;
`else
  localparam int         TO_DEC      = REFRESH_DIV;
  localparam logic [3:0] START_VALUE = 4'd7;
  localparam int         HELD_UNITS  = 5;
  localparam int         HELD_TENS   = 0;
  localparam int         HELD_DEC    = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value = 4'd0;
  logic       btn_in = 1'b0;
  logic [3:0] digit_bcd;
  logic       pin_uni;
  logic       pin_dec;
  logic       hold_led;

  typedef struct {
    logic [3:0] value;
    logic [3:0] exp_bcd;
    logic       exp_uni;
    logic       exp_dec;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  display_scan_ctrl #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .BLANK_CYC   (BLANK_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .btn_in   (btn_in),
    .digit_bcd(digit_bcd),
    .pin_uni  (pin_uni),
    .pin_dec  (pin_dec),
    .hold_led (hold_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] b, input logic u, input logic d);
    vec_t e;
    e.value   = v;
    e.exp_bcd = b;
    e.exp_uni = u;
    e.exp_dec = d;
    vecs.push_back(e);
  endtask

  // Advance until a units slot starts; bounded so a stuck scan cannot hang.
  task automatic wait_uni_entry(input string name);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = pin_uni;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (pin_uni && !prev) found = 1'b1;
      prev = pin_uni;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: units slot start seen 0 times in 64 cycles, required 1", name);
    end
  endtask

  task automatic press_button(input int cycles);
    btn_in = 1'b1;
    repeat (cycles) tick();
    btn_in = 1'b0;
    repeat (15) tick();
  endtask

  initial begin
    // Expected scan, one entry per clock after reset release.
`ifdef DISP_BLANKING_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) add(4'd12, 4'd2, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) add(4'd12, 4'd2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) add(4'd12, 4'd1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) add(4'd12, 4'd1, 1'b0, 1'b0);
    end
`else
    for (int i = 0; i < 4; i++) add(4'd7, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(4'd7, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(4'd13, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) add(4'd13, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) add(4'd5, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(4'd5, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(4'd5, 4'd0, 1'b0, 1'b0);
`endif

    // Reset state
    value  = START_VALUE;
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (2) tick();
    check("reset_bcd", digit_bcd, 0);
    check("reset_uni", pin_uni, 0);
    check("reset_dec", pin_dec, 0);
    check("reset_hold", hold_led, 0);

    // One idle cycle after release, all outputs low
    rst = 1'b0;
    #1;
    check("idle_bcd", digit_bcd, 0);
    check("idle_uni", pin_uni, 0);
    check("idle_dec", pin_dec, 0);

    // Scan vectors
    foreach (vecs[i]) begin
      value = vecs[i].value;
      tick();
      $display("vec %0d: value=%0d bcd=%0d uni=%0d dec=%0d", i, vecs[i].value, digit_bcd, pin_uni, pin_dec);
      check($sformatf("vec%0d_bcd", i), digit_bcd, vecs[i].exp_bcd);
      check($sformatf("vec%0d_uni", i), pin_uni, vecs[i].exp_uni);
      check($sformatf("vec%0d_dec", i), pin_dec, vecs[i].exp_dec);
      check($sformatf("vec%0d_overlap", i), pin_uni & pin_dec, 0);
    end

    // Short pulse ignored
    btn_in = 1'b1;
    repeat (5) tick();
    btn_in = 1'b0;
    repeat (12) tick();
    check("short_pulse_hold", hold_led, 0);
    $display("short pulse: hold_led=%0d", hold_led);

    // Long press: 2 sync + 8 debounce cycles
    btn_in = 1'b1;
    repeat (9) tick();
    check("hold_before_10", hold_led, 0);
    tick();
    check("hold_at_10", hold_led, 1);
    repeat (10) tick();
    btn_in = 1'b0;
    repeat (15) tick();
    check("release_no_toggle", hold_led, 1);
    $display("long press: hold_led=%0d", hold_led);

    // Frozen display ignores new value
    value = 4'd9;
    wait_uni_entry("held_uni_entry");
    check("held_units", digit_bcd, HELD_UNITS);
    repeat (TO_DEC) tick();
    check("held_tens", digit_bcd, HELD_TENS);
    check("held_dec_en", pin_dec, HELD_DEC);
    $display("held frame: tens=%0d dec=%0d", digit_bcd, pin_dec);

    // Second press releases hold; new value appears
    press_button(20);
    check("hold_cleared", hold_led, 0);
    wait_uni_entry("release_uni_entry");
    check("new_units", digit_bcd, 9);
    repeat (TO_DEC) tick();
    check("new_tens_bcd", digit_bcd, 0);
    check("new_tens_suppressed", pin_dec, 0);
    check("new_tens_uni_off", pin_uni, 0);
    $display("released frame: tens=%0d dec=%0d", digit_bcd, pin_dec);

    // Asynchronous reset mid tens slot with hold active
    value = 4'd13;
    wait_uni_entry("cap13_entry");
    press_button(20);
    check("hold_set_again", hold_led, 1);
    wait_uni_entry("pre_rst_entry");
    repeat (TO_DEC + 1) tick();
    check("pre_rst_dec", pin_dec, 1);
    check("pre_rst_bcd", digit_bcd, 1);
    rst = 1'b1;
    #1;
    check("async_rst_bcd", digit_bcd, 0);
    check("async_rst_uni", pin_uni, 0);
    check("async_rst_dec", pin_dec, 0);
    check("async_rst_hold", hold_led, 0);
    $display("async reset: bcd=%0d uni=%0d dec=%0d hold=%0d", digit_bcd, pin_uni, pin_dec, hold_led);
    repeat (2) tick();
    value = 4'd4;
    rst   = 1'b0;
    #1;
    check("restart_idle_uni", pin_uni, 0);
    tick();
    check("restart_bcd", digit_bcd, 4);
    check("restart_uni", pin_uni, 1);
    check("restart_hold", hold_led, 0);
    $display("restart: bcd=%0d uni=%0d hold=%0d", digit_bcd, pin_uni, hold_led);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 200000 reached, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
